// File: rtl/snn_udp_pkg.sv
// Shared constants, FSM encoding and byte-count helper for the SNN UDP transmit packer.
package snn_udp_pkg;

  localparam logic [7:0]  HDR_MAGIC = 8'h5A;
  localparam int unsigned HDR_LEN   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_HDR,
    ST_PAY,
    ST_WAIT_DONE
  } tx_state_e;

  // Header plus two bytes per event.
  function automatic logic [15:0] calc_byte_num(input logic [15:0] n);
    return 16'(HDR_LEN) + (n << 1);
  endfunction

endpackage

// File: rtl/snn_evt_fifo.sv
// Event buffer: synchronous FIFO with first-word-fall-through head and registered full/empty.
module snn_evt_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [15:0]   wdata_i,
  input  logic          pop_i,
  output logic [15:0]   head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/snn_udp_tx_packer.sv
// Buffers SNN spike events and frames them as UDP payloads: 4-byte header then 16-bit events, high byte first.
module snn_udp_tx_packer
  import snn_udp_pkg::*;
#(
  parameter int unsigned EVT_W      = 16,
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned FIFO_AW    = 8,
  parameter int unsigned MAX_EVT    = 128,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic             SNN_CLK,
  input  logic             sys_rst_n,
  input  logic             evt_valid,
  input  logic [EVT_W-1:0] evt_data,
  output logic             evt_ready,
  input  logic             flush,
  output logic             tx_start_en,
  output logic [15:0]      tx_byte_num,
  input  logic             tx_req,
  output logic [7:0]       tx_data,
  input  logic             udp_tx_done,
  output logic             busy,
  output logic [7:0]       seq_num,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned CNT_W    = FIFO_AW + 1;
  localparam logic [15:0] MAX_N    = 16'(MAX_EVT);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  tx_state_e   state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] byte_num_q, byte_num_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] idx_q, idx_d;

  logic [15:0] count16;
  logic [15:0] n_launch;
  logic        launch;

  snn_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (SNN_CLK),
    .rst_n   (sys_rst_n),
    .push_i  (evt_valid),
    .wdata_i (16'(evt_data)),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign count16  = 16'(fifo_count);
  assign n_launch = (count16 >= MAX_N) ? MAX_N : count16;
  assign launch   = !fifo_empty && ((count16 >= MAX_N) || (tmo_q == TMO_LAST) || flush);

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    byte_num_d = byte_num_q;
    seq_d      = seq_q;
    tx_data_d  = tx_data_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    drop_d     = drop_q;
    tmo_d      = 16'd0;
    idx_d      = idx_q;
    fifo_pop   = 1'b0;

    if (evt_valid && fifo_full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    if (tx_req && (state_q != ST_HDR) && (state_q != ST_PAY)) tx_data_d = 8'h00;

    // Completion or early abort: unserved events stay buffered for the next packet.
    if ((state_q != ST_IDLE) && udp_tx_done) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            n_d        = n_launch;
            byte_num_d = calc_byte_num(n_launch);
            seq_d      = seq_q + 8'd1;
            start_d    = 1'b1;
            busy_d     = 1'b1;
            idx_d      = 16'd0;
            state_d    = ST_START;
          end else if (!fifo_empty) begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        ST_START: state_d = ST_HDR;
        ST_HDR: begin
          if (tx_req) begin
            case (idx_q[1:0])
              2'd0:    tx_data_d = HDR_MAGIC;
              2'd1:    tx_data_d = seq_q;
              2'd2:    tx_data_d = n_q[15:8];
              default: tx_data_d = n_q[7:0];
            endcase
            if (idx_q == 16'(HDR_LEN - 1)) begin
              idx_d   = 16'd0;
              state_d = ST_PAY;
            end else begin
              idx_d = idx_q + 16'd1;
            end
          end
        end
        ST_PAY: begin
          // Pop on the low byte so the head is still valid for the high byte.
          if (tx_req) begin
            tx_data_d = idx_q[0] ? fifo_head[7:0] : fifo_head[15:8];
            fifo_pop  = idx_q[0];
            if (idx_q == (n_q << 1) - 16'd1) state_d = ST_WAIT_DONE;
            else                             idx_d   = idx_q + 16'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge SNN_CLK or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= 16'd0;
      byte_num_q <= 16'd0;
      seq_q      <= 8'd0;
      tx_data_q  <= 8'd0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 16'd0;
      tmo_q      <= 16'd0;
      idx_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      byte_num_q <= byte_num_d;
      seq_q      <= seq_d;
      tx_data_q  <= tx_data_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      tmo_q      <= tmo_d;
      idx_q      <= idx_d;
    end
  end

  assign evt_ready   = !fifo_full;
  assign tx_start_en = start_q;
  assign tx_byte_num = byte_num_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign seq_num     = seq_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_snn_udp_tx_packer.sv
// Bench for snn_udp_tx_packer: queue-based packet model checked every cycle, plus literal expectations.
module tb_snn_udp_tx_packer;

  localparam int unsigned EVT_W      = 16;
  localparam int unsigned FIFO_DEPTH = 256;
  localparam int unsigned FIFO_AW    = 8;
  localparam int unsigned MAX_EVT    = 128;
  localparam int unsigned TIMEOUT    = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        evt_valid = 1'b0;
  logic [15:0] evt_data = 16'h0;
  logic        evt_ready;
  logic        flush = 1'b0;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data;
  logic        udp_tx_done = 1'b0;
  logic        busy;
  logic [7:0]  seq_num;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snn_udp_tx_packer #(
    .EVT_W(EVT_W), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW),
    .MAX_EVT(MAX_EVT), .TIMEOUT(TIMEOUT)
  ) dut (
    .SNN_CLK(clk), .sys_rst_n(rst_n), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_ready(evt_ready), .flush(flush), .tx_start_en(tx_start_en),
    .tx_byte_num(tx_byte_num), .tx_req(tx_req), .tx_data(tx_data),
    .udp_tx_done(udp_tx_done), .busy(busy), .seq_num(seq_num), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: event queue, pending packet byte list, timer and flags.
  logic [15:0] mq[$];
  logic [7:0]  pkt[$];
  bit          m_busy, m_start;
  logic [15:0] m_bn, m_drop;
  logic [7:0]  m_seq, m_data;
  int          m_tmo, m_served;

  always @(posedge clk or negedge rst_n) begin
    int sz;
    int n;
    if (!rst_n) begin
      mq.delete(); pkt.delete();
      m_busy = 0; m_start = 0; m_bn = 0; m_drop = 0;
      m_seq = 0; m_data = 0; m_tmo = 0; m_served = 0;
    end else begin
      sz = mq.size();
      if (m_busy) begin
        if (udp_tx_done) begin
          m_busy = 0;
          pkt.delete();
        end else if (tx_req) begin
          if (m_start || pkt.size() == 0) m_data = 8'h00;
          else begin
            m_data = pkt.pop_front();
            m_served++;
            if (m_served > 4 && (m_served % 2) == 0) void'(mq.pop_front());
          end
        end
        m_start = 0;
        m_tmo = 0;
      end else begin
        if (tx_req) m_data = 8'h00;
        if (sz > 0 && (sz >= int'(MAX_EVT) || m_tmo == int'(TIMEOUT) - 1 || flush)) begin
          n = (sz >= int'(MAX_EVT)) ? int'(MAX_EVT) : sz;
          m_seq = m_seq + 8'd1;
          m_bn = 16'(4 + 2 * n);
          pkt.delete();
          pkt.push_back(8'h5A);
          pkt.push_back(m_seq);
          pkt.push_back(8'(n >> 8));
          pkt.push_back(8'(n));
          for (int i = 0; i < n; i++) begin
            pkt.push_back(mq[i][15:8]);
            pkt.push_back(mq[i][7:0]);
          end
          m_busy = 1; m_start = 1; m_served = 0; m_tmo = 0;
        end else begin
          m_tmo = (sz > 0) ? m_tmo + 1 : 0;
        end
      end
      if (evt_valid) begin
        if (sz < int'(FIFO_DEPTH)) mq.push_back(evt_data);
        else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    check("evt_ready",   32'(evt_ready),   32'(mq.size() < int'(FIFO_DEPTH)));
    check("tx_start_en", 32'(tx_start_en), 32'(m_start));
    check("busy",        32'(busy),        32'(m_busy));
    check("tx_byte_num", 32'(tx_byte_num), 32'(m_bn));
    check("seq_num",     32'(seq_num),     32'(m_seq));
    check("tx_data",     32'(tx_data),     32'(m_data));
    check("drop_cnt",    32'(drop_cnt),    32'(m_drop));
  end

  // Stimulus tasks: called and returning at posedge+1.
  task automatic push(input logic [15:0] d);
    evt_valid = 1'b1; evt_data = d;
    @(posedge clk); #1;
    evt_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
  endtask

  task automatic pulse_done();
    udp_tx_done = 1'b1; @(posedge clk); #1; udp_tx_done = 1'b0;
  endtask

  task automatic req_byte(output logic [7:0] b);
    @(posedge clk); #1; tx_req = 1'b1;
    @(posedge clk); #1; tx_req = 1'b0;
    b = tx_data;
  endtask

  task automatic serve(input int nb);
    logic [7:0] b;
    for (int i = 0; i < nb; i++) req_byte(b);
  endtask

  // Returns number of falling edges until tx_start_en; an expired budget is a failure.
  task automatic wait_start(input int budget, output int cyc);
    cyc = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (tx_start_en) begin cyc = k; break; end
    end
    tests++;
    if (cyc < 0) begin
      fails++;
      $display("FAIL wait_start: no tx_start_en within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    evt_valid = 0; flush = 0; tx_req = 0; udp_tx_done = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp1 [10];
    logic [7:0] b;
    int cyc;
    exp1 = '{8'h5A, 8'h01, 8'h00, 8'h03, 8'h00, 8'h12, 8'h03, 8'h45, 8'h0A, 8'hBC};

    do_reset();
    check("rst_evt_ready", 32'(evt_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_byte_num", 32'(tx_byte_num), 32'd0);
    check("rst_seq", 32'(seq_num), 32'd0);

    // Three events then flush.
    push(16'h0012); push(16'h0345); push(16'h0ABC);
    pulse_flush();
    wait_start(20, cyc);
    check("t1_start_lat", 32'(cyc), 32'd1);
    check("t1_byte_num", 32'(tx_byte_num), 32'd10);
    for (int i = 0; i < 10; i++) begin
      req_byte(b);
      check($sformatf("t1_byte%0d", i), 32'(b), 32'(exp1[i]));
    end
    pulse_done();
    check("t1_busy_after", 32'(busy), 32'd0);
    req_byte(b);
    check("t1_idle_req", 32'(b), 32'h00);

    // 130 events: full packet of 128, then a 2-event packet on timeout.
    do_reset();
    for (int i = 0; i < 130; i++) push(16'(i * 7 + 16'h0100));
    check("t2_byte_num", 32'(tx_byte_num), 32'd260);
    check("t2_seq1", 32'(seq_num), 32'd1);
    serve(260);
    pulse_done();
    wait_start(TIMEOUT + 20, cyc);
    check("t2_byte_num2", 32'(tx_byte_num), 32'd8);
    check("t2_seq2", 32'(seq_num), 32'd2);
    serve(3);
    req_byte(b);
    check("t2_n_lo", 32'(b), 32'd2);
    serve(4);
    pulse_done();

    // Single event, no flush: launched by timeout.
    do_reset();
    push(16'h0042);
    wait_start(TIMEOUT + 20, cyc);
    check("t3_start_lat", 32'(cyc), 32'(TIMEOUT + 1));
    check("t3_byte_num", 32'(tx_byte_num), 32'd6);
    serve(6);
    pulse_done();

    // Fill the buffer while the engine stalls, then overflow by 5.
    do_reset();
    for (int i = 0; i < 256; i++) push(16'(i));
    check("t4_full_ready", 32'(evt_ready), 32'd0);
    for (int i = 0; i < 5; i++) push(16'hDEAD);
    check("t4_drop", 32'(drop_cnt), 32'd5);
    serve(260);
    pulse_done();
    wait_start(10, cyc);
    check("t4_byte_num2", 32'(tx_byte_num), 32'd260);
    check("t4_seq2", 32'(seq_num), 32'd2);
    serve(260);
    pulse_done();

    // Early done after two header bytes: all events remain.
    do_reset();
    for (int i = 0; i < 4; i++) push(16'(16'h0A00 + i));
    pulse_flush();
    wait_start(20, cyc);
    serve(2);
    pulse_done();
    check("t5_busy_abort", 32'(busy), 32'd0);
    pulse_flush();
    wait_start(20, cyc);
    check("t5_byte_num", 32'(tx_byte_num), 32'd12);
    check("t5_seq", 32'(seq_num), 32'd2);
    serve(12);
    pulse_done();

    // Reset mid-payload.
    do_reset();
    push(16'h1111); push(16'h2222); push(16'h3333);
    pulse_flush();
    wait_start(20, cyc);
    serve(5);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_data", 32'(tx_data), 32'd0);
    check("t6_rst_bn", 32'(tx_byte_num), 32'd0);
    check("t6_rst_seq", 32'(seq_num), 32'd0);
    check("t6_rst_ready", 32'(evt_ready), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_flush();
    repeat (20) @(posedge clk);
    #1;
    check("t6_empty_flush", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/snn_udp_tx_packer.md
Name: snn_udp_tx_packer

Overview:
- Transmit-side companion to the UDP receive path. Collects SNN output spike events (neuron indices) from the core, buffers them, and frames them into UDP payloads.
- Drives the UDP engine's user transmit interface: tx_start_en, tx_byte_num, tx_req and tx_data, and consumes udp_tx_done.
- Sits between the SNN core and eth_udp_loop_snn. At integration, the UDP transmit user interface is in the SNN_CLK domain.

Parameters:
- EVT_W, 16: event (neuron index) width, ≤16. Zero-extended to 16 bits on the wire.
- FIFO_DEPTH, 256: event buffer depth, power of 2.
- FIFO_AW, 8: log2(FIFO_DEPTH).
- MAX_EVT, 128: maximum events per packet.
- TIMEOUT, 4096: idle cycles after which a partial packet is sent.

Ports:
- SNN_CLK  in  1  sole clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- evt_valid  in  1  spike event offered.
- evt_data  in  EVT_W  neuron index.
- evt_ready  out  1  buffer can accept an event.
- flush  in  1  one-cycle request to send pending events now.
- tx_start_en  out  1  one-cycle packet start pulse to the UDP engine.
- tx_byte_num  out  16  payload byte count, held stable until udp_tx_done.
- tx_req  in  1  UDP engine byte request.
- tx_data  out  8  payload byte.
- udp_tx_done  in  1  one-cycle packet-sent pulse.
- busy  out  1  packet in flight.
- seq_num  out  8  sequence number of the last started packet.
- drop_cnt  out  16  events dropped because the buffer was full (saturating).

Behaviour:
- Reset: every output is 0 except evt_ready, which is 1. FIFO is empty, FSM is in IDLE, seq counter is 0, timeout counter is 0.
- Event input:
  - An event is pushed when evt_valid && evt_ready.
  - evt_ready = !fifo_full.
  - evt_valid while full: the event is dropped and drop_cnt increments, saturating at 0xFFFF.
  - Events are accepted in every FSM state.
- FSM states: IDLE, START, HDR, PAY, WAIT_DONE.
- IDLE:
  - Timeout counter increments each cycle while the FIFO is non-empty; it is cleared when the FIFO is empty.
  - Launch condition: count ≥ MAX_EVT, or timeout counter = TIMEOUT−1, or (flush and count > 0). flush with an empty FIFO is ignored.
  - On launch:
    - N = min(count, MAX_EVT), latched.
    - tx_byte_num = 4 + 2N, registered.
    - seq counter increments; seq_num takes the new value.
    - Next state is START.
- START: tx_start_en = 1 for exactly one cycle, busy = 1. Next state is HDR.
- Byte serving (HDR and PAY):
  - tx_data is registered. For a tx_req sampled in cycle k, the next byte appears on tx_data in cycle k+1 and holds until the next tx_req.
  - Header bytes: 0x5A, seq_num, N[15:8], N[7:0]. After the 4th request, next state is PAY.
  - Payload per event: bits [15:8] first, then bits [7:0]. The FIFO pops on the low-byte request, so the head stays valid across the high byte.
  - After 2N payload requests, next state is WAIT_DONE.
- tx_req outside HDR/PAY: tx_data = 0x00. The request is ignored and no pop occurs.
- WAIT_DONE: hold tx_byte_num. On udp_tx_done go to IDLE; busy = 0 and the timeout counter is cleared.
- udp_tx_done arriving before all bytes are served: abort to IDLE. Already popped events are lost; unpopped events remain in the FIFO. No retry.
- Simultaneous push and pop: FIFO count is unchanged.
- Events arriving during a packet are held for the next packet. They are never counted into the current N.
- Reset mid-packet: immediate return to reset state and the FIFO is flushed.
- Sequence counter wraps 0xFF → 0x00.

Decomposition:
- Shared package snn_udp_pkg holds:
  - constants HDR_MAGIC = 8'h5A and HDR_LEN = 4;
  - the FSM state encoding;
  - a function computing byte count from N.
- Sub-module snn_evt_fifo: synchronous FIFO, FIFO_DEPTH × 16, with first-word-fall-through head, count, full and empty outputs.

Test Plan:
- Push 3 events (0x0012, 0x0345, 0x0ABC), then pulse flush:
  - tx_start_en pulses once, tx_byte_num = 10.
  - Bytes served on 10 tx_req: 5A 01 00 03 00 12 03 45 0A BC.
  - udp_tx_done → busy = 0.
- Push 130 events back to back:
  - First packet has N = 128, tx_byte_num = 260.
  - After udp_tx_done and TIMEOUT idle cycles, a second packet has N = 2 with seq = 02.
- Push 1 event, no flush: tx_start_en asserts exactly TIMEOUT+1 cycles after the push, tx_byte_num = 6.
- Fill 256 events with tx_req held low, then offer 5 more: evt_ready = 0 and drop_cnt = 5. Normal packets follow.
- Pulse udp_tx_done after only 2 header bytes have been served: FSM returns to IDLE, and the FIFO still holds all events.
- Assert sys_rst_n low mid-payload: all outputs return to reset values within the same cycle, and the FIFO is empty afterward.
